// File: rtl/prog_seq_pkg.sv
// ---------------------------------------------------------------------------
// prog_seq_pkg
// Shared types and constants for the program sequencer.
//   seq_state_t : run-control states (IDLE, RUN, DONE)
//   pc_sel_t    : next-PC source selected each cycle
//   LUT_DEFAULT : default jump-target table, entry i = i*4 (the caller
//                 truncates the result to the PC width, i.e. mod 2**D)
// No ports; imported by prog_sequencer and ret_stack.
// ---------------------------------------------------------------------------
package prog_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_t;

    typedef enum logic [2:0] {
        HOLD,
        INC,
        REL,
        ABS,
        CALL,
        RET
    } pc_sel_t;

    localparam int unsigned LUT_STEP = 4;

    // Default jump target for a LUT index, before truncation to D bits.
    function automatic int unsigned LUT_DEFAULT(input int unsigned idx);
        return idx * LUT_STEP;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// ---------------------------------------------------------------------------
// ret_stack
// Hardware LIFO of return addresses for call/return.
// Parameters: D (address width), S (depth in entries, S >= 1).
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : synchronous clear of the occupancy (stack emptied)
//   i_push, i_dat  : push i_dat (ignored when full)
//   i_pop          : discard the top entry (ignored when empty)
//   o_top          : current top entry (valid when not empty)
//   o_full/o_empty : occupancy flags
//   o_count        : occupancy 0..S
// ---------------------------------------------------------------------------
module ret_stack
    import prog_seq_pkg::*;
#(
    parameter int D = 9,
    parameter int S = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clr,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [D-1:0]           i_dat,
    output logic [D-1:0]           o_top,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(S+1)-1:0] o_count
);

    localparam int CW = $clog2(S+1);
    localparam int IW = (S > 1) ? $clog2(S) : 1;

    logic [D-1:0]  r_mem [S];
    logic [CW-1:0] r_count;

    // The top entry sits one below the occupancy count.
    assign o_top   = r_mem[IW'(r_count - CW'(1))];
    assign o_full  = (r_count == CW'(S));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // Storage and occupancy; clear wins over push/pop so a finished run
    // always hands back an empty stack.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            for (int i = 0; i < S; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_push && !o_full) begin
            r_mem[IW'(r_count)] <= i_dat;
            r_count             <= r_count + CW'(1);
        end else if (i_pop && !o_empty) begin
            r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// ---------------------------------------------------------------------------
// prog_sequencer
// Program sequencer: starts a run on i_req, steps o_prog_ctr, resolves
// relative/absolute jumps through a target LUT, and supports call/return
// through ret_stack, stall hold, halt and a 4-phase req/done handshake.
// Parameters: D (PC width), L (LUT index width), S (stack depth),
//             END_PC (address that completes the program).
// Ports:
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_req / o_done      : 4-phase start/finish handshake
//   o_busy              : high while running
//   o_fault             : run ended by stack overflow/underflow
//   i_stall             : freeze the sequencer this cycle
//   i_halt              : end the run
//   i_reljump_en        : PC <= PC + lut[i_lut_idx]
//   i_absjump_en        : PC <= lut[i_lut_idx]
//   i_call_en           : push PC+1, PC <= lut[i_lut_idx]
//   i_ret_en            : PC <= popped address
//   i_lut_idx           : LUT index for jump/call
//   o_prog_ctr          : current instruction address
//   o_sp                : return-stack occupancy
// Optional macro PROG_SEQ_LUT_WR_EN adds i_lut_wr_en/i_lut_wr_idx/
// i_lut_wr_dat: LUT writes accepted only in IDLE; reset restores defaults.
// Without it the LUT is the constant default table.
// ---------------------------------------------------------------------------
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int D      = 9,
    parameter int L      = 5,
    parameter int S      = 4,
    parameter int END_PC = 128
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_req,
    output logic                   o_done,
    output logic                   o_busy,
    output logic                   o_fault,
    input  logic                   i_stall,
    input  logic                   i_halt,
    input  logic                   i_reljump_en,
    input  logic                   i_absjump_en,
    input  logic                   i_call_en,
    input  logic                   i_ret_en,
    input  logic [L-1:0]           i_lut_idx,
    output logic [D-1:0]           o_prog_ctr,
    output logic [$clog2(S+1)-1:0] o_sp
`ifdef PROG_SEQ_LUT_WR_EN
    ,
    input  logic                   i_lut_wr_en,
    input  logic [L-1:0]           i_lut_wr_idx,
    input  logic [D-1:0]           i_lut_wr_dat
`endif
);

    localparam int N = 2 ** L;

    seq_state_t   r_state;
    logic [D-1:0] r_pc;
    logic         r_done;
    logic         r_busy;
    logic         r_fault;

    pc_sel_t      w_pcSel;
    logic         w_endRun;
    logic         w_faultRun;
    logic [D-1:0] w_lutVal;
    logic [D-1:0] w_nextPc;
    logic [D-1:0] w_stackTop;
    logic         w_full;
    logic         w_empty;
    logic         w_push;
    logic         w_pop;
    logic         w_clr;

`ifdef PROG_SEQ_LUT_WR_EN
    logic [D-1:0] r_lut [N];

    // Writable target table; writes outside IDLE are dropped so a running
    // program never sees its jump targets change underneath it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_lut[i] <= D'(LUT_DEFAULT(i));
            end
        end else if (i_lut_wr_en && (r_state == IDLE)) begin
            r_lut[i_lut_wr_idx] <= i_lut_wr_dat;
        end
    end

    assign w_lutVal = r_lut[i_lut_idx];
`else
    logic [D-1:0] w_lut [N];

    for (genvar g = 0; g < N; g++) begin : g_lut
        assign w_lut[g] = D'(LUT_DEFAULT(g));
    end

    assign w_lutVal = w_lut[i_lut_idx];
`endif

    // Priority decode of the strobes: end > ret > call > absj > relj > inc.
    // A stack fault ends the run instead of moving the PC.
    always_comb begin
        w_pcSel    = HOLD;
        w_endRun   = 1'b0;
        w_faultRun = 1'b0;
        if ((r_state == RUN) && !i_stall) begin
            if ((r_pc == D'(END_PC)) || i_halt) begin
                w_endRun = 1'b1;
            end else if (i_ret_en) begin
                if (w_empty) begin
                    w_endRun   = 1'b1;
                    w_faultRun = 1'b1;
                end else begin
                    w_pcSel = RET;
                end
            end else if (i_call_en) begin
                if (w_full) begin
                    w_endRun   = 1'b1;
                    w_faultRun = 1'b1;
                end else begin
                    w_pcSel = CALL;
                end
            end else if (i_absjump_en) begin
                w_pcSel = ABS;
            end else if (i_reljump_en) begin
                w_pcSel = REL;
            end else begin
                w_pcSel = INC;
            end
        end
    end

    // Next-PC mux; all additions wrap modulo 2**D by truncation.
    always_comb begin
        w_nextPc = r_pc;
        case (w_pcSel)
            INC:         w_nextPc = r_pc + D'(1);
            REL:         w_nextPc = r_pc + w_lutVal;
            ABS, CALL:   w_nextPc = w_lutVal;
            RET:         w_nextPc = w_stackTop;
            default:     w_nextPc = r_pc;
        endcase
    end

    assign w_push = (w_pcSel == CALL);
    assign w_pop  = (w_pcSel == RET);
    assign w_clr  = (r_state == DONE) && !i_req;

    ret_stack #(
        .D(D),
        .S(S)
    ) u_retStack (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_dat   (r_pc + D'(1)),
        .o_top   (w_stackTop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_sp)
    );

    // Run-control FSM with registered handshake outputs. The PC freezes in
    // DONE so the finishing address stays observable until req drops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req) begin
                        r_state <= RUN;
                        r_pc    <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_endRun) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_fault <= w_faultRun;
                    end else begin
                        r_pc <= w_nextPc;
                    end
                end
                DONE: begin
                    if (!i_req) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                        r_fault <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_prog_ctr = r_pc;
    assign o_done     = r_done;
    assign o_busy     = r_busy;
    assign o_fault    = r_fault;

endmodule

// File: tb/tb_prog_sequencer.sv
// ---------------------------------------------------------------------------
// tb_prog_sequencer
// Self-checking bench for prog_sequencer (D=9, L=5, S=4, END_PC=128):
// a directed vector table, hand-written multi-cycle sequences, and a
// randomized run compared against a queue-based behavioural model.
// ---------------------------------------------------------------------------
module tb_prog_sequencer;

    localparam int D      = 9;
    localparam int L      = 5;
    localparam int S      = 4;
    localparam int END_PC = 128;
    localparam int PCMOD  = 2 ** D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req = 1'b0, stall = 1'b0, halt = 1'b0;
    logic         relEn = 1'b0, absEn = 1'b0, callEn = 1'b0, retEn = 1'b0;
    logic [L-1:0] lutIdx = '0;
    logic         done, busy, fault;
    logic [D-1:0] progCtr;
    logic [2:0]   sp;
`ifdef PROG_SEQ_LUT_WR_EN
    logic         lutWrEn = 1'b0;
    logic [L-1:0] lutWrIdx = '0;
    logic [D-1:0] lutWrDat = '0;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state: plain flags, an integer PC and a queue stack.
    bit mRun, mDone, mFault;
    int mPc;
    int mStk[$];
    int mLut[2**L];

    prog_sequencer #(.D(D), .L(L), .S(S), .END_PC(END_PC)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req        (req),
        .o_done       (done),
        .o_busy       (busy),
        .o_fault      (fault),
        .i_stall      (stall),
        .i_halt       (halt),
        .i_reljump_en (relEn),
        .i_absjump_en (absEn),
        .i_call_en    (callEn),
        .i_ret_en     (retEn),
        .i_lut_idx    (lutIdx),
        .o_prog_ctr   (progCtr),
        .o_sp         (sp)
`ifdef PROG_SEQ_LUT_WR_EN
        ,
        .i_lut_wr_en  (lutWrEn),
        .i_lut_wr_idx (lutWrIdx),
        .i_lut_wr_dat (lutWrDat)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       req, stall, halt, rel, abs, call, ret;
        logic [4:0] idx;
        int         expPc, expSp;
        logic       expDone, expBusy, expFault;
        bit         chkPc;
    } vec_t;

    vec_t vecs[16];

    // Drive all strobe inputs at once.
    task automatic applyStimulus(input logic rq, st, hl, rl, ab, cl, rt,
                                 input logic [4:0] ix);
        req = rq; stall = st; halt = hl; relEn = rl;
        absEn = ab; callEn = cl; retEn = rt; lutIdx = ix;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input int pc, input int spv,
                            input int dn, input int bs, input int ft, input bit chkPc);
        if (chkPc) checkOutput({tag, ".pc"}, int'(progCtr), pc);
        checkOutput({tag, ".sp"},    int'(sp),    spv);
        checkOutput({tag, ".done"},  int'(done),  dn);
        checkOutput({tag, ".busy"},  int'(busy),  bs);
        checkOutput({tag, ".fault"}, int'(fault), ft);
    endtask

    task automatic modelReset();
        mRun = 0; mDone = 0; mFault = 0; mPc = 0;
        mStk.delete();
        for (int i = 0; i < 2**L; i++) mLut[i] = (i * 4) % PCMOD;
    endtask

    // One clock of the reference behaviour.
    task automatic modelStep(input bit rq, st, hl, rl, ab, cl, rt, input int ix);
        if (mRun) begin
            if (!st) begin
                if (mPc == END_PC || hl) begin
                    mRun = 0; mDone = 1;
                end else if (rt) begin
                    if (mStk.size() == 0) begin mRun = 0; mDone = 1; mFault = 1; end
                    else mPc = mStk.pop_back();
                end else if (cl) begin
                    if (mStk.size() == S) begin mRun = 0; mDone = 1; mFault = 1; end
                    else begin mStk.push_back((mPc + 1) % PCMOD); mPc = mLut[ix]; end
                end else if (ab) mPc = mLut[ix];
                else if (rl) mPc = (mPc + mLut[ix]) % PCMOD;
                else mPc = (mPc + 1) % PCMOD;
            end
        end else if (mDone) begin
            if (!rq) begin mDone = 0; mFault = 0; mStk.delete(); end
        end else if (rq) begin
            mRun = 1; mPc = 0;
        end
    endtask

    task automatic doReset(input string tag);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll({tag, ".reset"}, 0, 0, 0, 0, 0, 1);
        rst_n = 1'b1;
    endtask

    initial begin
        // ------------------------------------------------ directed table
        //            req st hl rl ab cl rt idx  pc  sp dn bs ft chk
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 1};
        vecs[1]  = '{1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 1};
        vecs[2]  = '{1, 0, 0, 0, 1, 0, 0, 3,  12, 0, 0, 1, 0, 1};
        vecs[3]  = '{1, 0, 0, 0, 0, 1, 0, 10, 40, 1, 0, 1, 0, 1};
        vecs[4]  = '{1, 1, 0, 0, 0, 1, 0, 1,  40, 1, 0, 1, 0, 1};
        vecs[5]  = '{1, 0, 0, 1, 0, 0, 0, 2,  48, 1, 0, 1, 0, 1};
        vecs[6]  = '{1, 0, 0, 0, 0, 0, 1, 0,  13, 0, 0, 1, 0, 1};
        vecs[7]  = '{1, 0, 0, 1, 1, 1, 0, 5,  20, 1, 0, 1, 0, 1};
        vecs[8]  = '{1, 0, 0, 0, 0, 1, 1, 7,  14, 0, 0, 1, 0, 1};
        vecs[9]  = '{1, 0, 0, 0, 0, 0, 1, 0,  14, 0, 1, 0, 1, 1};
        vecs[10] = '{1, 0, 0, 0, 1, 0, 0, 3,  14, 0, 1, 0, 1, 1};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
        vecs[12] = '{1, 0, 0, 0, 1, 0, 1, 3,   0, 0, 0, 1, 0, 1};
        vecs[13] = '{1, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 1};
        vecs[14] = '{1, 0, 1, 0, 0, 1, 0, 1,   0, 0, 1, 0, 0, 1};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};

        doReset("table");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].req, vecs[i].stall, vecs[i].halt, vecs[i].rel,
                          vecs[i].abs, vecs[i].call, vecs[i].ret, vecs[i].idx);
            step();
            checkAll($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expSp,
                     vecs[i].expDone, vecs[i].expBusy, vecs[i].expFault, vecs[i].chkPc);
        end

        // ------------------------------------------------ run to END_PC
        doReset("end");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        checkAll("end.start", 0, 0, 0, 1, 0, 1);
        for (int k = 1; k <= END_PC; k++) begin
            step();
            checkOutput($sformatf("end.pc%0d", k), int'(progCtr), k);
        end
        step();
        checkAll("end.done", END_PC, 0, 1, 0, 0, 1);
        step();
        checkAll("end.hold", END_PC, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        checkAll("end.idle", 0, 0, 0, 0, 0, 0);

        // ------------------------------------------------ relative wrap
        doReset("wrap");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 30);
        step();
        checkOutput("wrap.abs", int'(progCtr), 120);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 31);
        step();
        checkOutput("wrap.rel1", int'(progCtr), 244);
        step();
        step();
        checkOutput("wrap.rel3", int'(progCtr), 492);
        step();
        checkOutput("wrap.rel4", int'(progCtr), 104);

        // ------------------------------------------------ overflow / underflow
        doReset("ovf");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 1);
        for (int k = 1; k <= S; k++) begin
            step();
            checkAll($sformatf("ovf.call%0d", k), 4, k, 0, 1, 0, 1);
        end
        step();
        checkAll("ovf.fault", 4, S, 1, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        checkAll("ovf.idle", 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
        step();
        checkAll("unf.fault", 0, 0, 1, 0, 1, 1);

        // ------------------------------------------------ call/stall/ret
        doReset("cr");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 1);
        step();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        checkOutput("cr.pc5", int'(progCtr), 5);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 10);
        step();
        checkAll("cr.call", 40, 1, 0, 1, 0, 1);
        applyStimulus(1, 1, 1, 0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            checkAll($sformatf("cr.stall%0d", k), 40, 1, 0, 1, 0, 1);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
        step();
        checkAll("cr.ret", 6, 0, 0, 1, 0, 1);

        // ------------------------------------------------ async reset mid-run
        doReset("ar");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 9);
        step();
        step();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        checkAll("ar.before", 37, 2, 0, 1, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("ar.async", 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        checkAll("ar.idle", 0, 0, 0, 0, 0, 1);

        // ------------------------------------------------ randomized vs model
        doReset("rnd");
        for (int c = 0; c < 3000; c++) begin
            bit rq, st, hl, rl, ab, cl, rt;
            int ix;
            if (mRun)       rq = ($urandom_range(0, 7) != 0);
            else if (mDone) rq = ($urandom_range(0, 2) != 0);
            else            rq = ($urandom_range(0, 1) != 0);
            st = ($urandom_range(0, 4) == 0);
            hl = ($urandom_range(0, 63) == 0);
            rl = ($urandom_range(0, 9) == 0);
            ab = ($urandom_range(0, 9) == 0);
            cl = ($urandom_range(0, 9) == 0);
            rt = ($urandom_range(0, 9) == 0);
            ix = $urandom_range(0, 2**L - 1);
            applyStimulus(rq, st, hl, rl, ab, cl, rt, ix[4:0]);
            modelStep(rq, st, hl, rl, ab, cl, rt, ix);
            step();
            checkAll($sformatf("rnd%0d", c), mPc, mStk.size(), mDone, mRun, mFault,
                     mRun || mDone);
        end

`ifdef PROG_SEQ_LUT_WR_EN
        // ------------------------------------------------ LUT write port
        doReset("wr");
        lutWrEn = 1'b1; lutWrIdx = 1; lutWrDat = 99;
        step();
        lutWrIdx = 3; lutWrDat = 510;
        step();
        lutWrEn = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        lutWrEn = 1'b1; lutWrIdx = 2; lutWrDat = 77;
        step();
        lutWrEn = 1'b0;
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 1);
        step();
        checkOutput("wr.abs1", int'(progCtr), 99);
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 2);
        step();
        checkOutput("wr.runDropped", int'(progCtr), 8);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 3);
        step();
        checkOutput("wr.relNeg", int'(progCtr), 6);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
